transformation_engine: RTL and testbench

- Parametrised feature-matrix × weight-matrix transformation stage for the GNN datapath.
- Fetches one weight column and then every feature row from shared memory over a request/valid read port.
- Forms each unsigned dot product and stores it in an internal FEATURE_ROWS × WEIGHT_COLS result buffer.
- Downstream aggregation reads the buffer one row at a time.

---
 rtl/transformation_engine.sv | 166 ++++++++++++++++
 tb/tb_transformation_engine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/transformation_engine.sv
// Feature x weight transformation stage: fetches a weight column, then every feature row, and
// stores each dot product in a row-readable buffer. Define TRANSFORM_SAT_EN to clamp instead of wrap.
module transformation_engine #(
   parameter int FEATURE_ROWS   = 6,
   parameter int WEIGHT_COLS    = 3,
   parameter int VEC_LEN        = 96,
   parameter int FEATURE_WIDTH  = 5,
   parameter int WEIGHT_WIDTH   = 5,
   parameter int DOT_PROD_WIDTH = 16,
   parameter int ADDR_WIDTH     = 13,
   parameter int WEIGHT_BASE    = 0,
   parameter int FEATURE_BASE   = 512,
   localparam int ELEM_W = (FEATURE_WIDTH > WEIGHT_WIDTH) ? FEATURE_WIDTH : WEIGHT_WIDTH
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic                                   start,
   input  logic                                   mem_valid,
   input  logic [VEC_LEN*ELEM_W-1:0]              data_in,
   input  logic [$clog2(FEATURE_ROWS)-1:0]        read_row,
   output logic                                   read_en,
   output logic [ADDR_WIDTH-1:0]                  read_address,
   output logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0]  fm_wm_row_out,
   output logic                                   busy,
   output logic                                   done
);

   localparam int SUM_W = FEATURE_WIDTH + WEIGHT_WIDTH + $clog2(VEC_LEN);
   localparam int ROW_W = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
   localparam int COL_W = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FEATURE_ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WEIGHT_COLS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ_W  = 3'd1,
      S_WAIT_W = 3'd2,
      S_REQ_F  = 3'd3,
      S_WAIT_F = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t                              state_r;
   logic [ROW_W-1:0]                    row_cnt_r;
   logic [COL_W-1:0]                    col_cnt_r;
   logic [VEC_LEN*WEIGHT_WIDTH-1:0]     weight_r;
   logic [DOT_PROD_WIDTH-1:0]           buffer_r [FEATURE_ROWS][WEIGHT_COLS];
   logic                                read_en_r;
   logic [ADDR_WIDTH-1:0]               read_address_r;
   logic                                busy_r;
   logic                                done_r;

   logic [VEC_LEN*WEIGHT_WIDTH-1:0]     weight_s;
   logic [SUM_W-1:0]                    sum_s;
   logic [DOT_PROD_WIDTH-1:0]           dot_s;
   logic [ROW_W-1:0]                    row_nxt_s;
   logic [COL_W-1:0]                    col_nxt_s;

   assign read_en      = read_en_r;
   assign read_address = read_address_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign row_nxt_s    = row_cnt_r + ROW_W'(1);
   assign col_nxt_s    = col_cnt_r + COL_W'(1);

   // Unpack the incoming vector and form the full-width dot product against the scratch pad.
   always_comb begin
      weight_s = '0;
      sum_s    = '0;
      for (int i = 0; i < VEC_LEN; i++) begin
         weight_s[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = data_in[i*ELEM_W +: WEIGHT_WIDTH];
         sum_s = sum_s + SUM_W'(data_in[i*ELEM_W +: FEATURE_WIDTH])
                       * SUM_W'(weight_r[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      end
`ifdef TRANSFORM_SAT_EN
      if (sum_s > SUM_W'((64'd1 << DOT_PROD_WIDTH) - 64'd1)) begin
         dot_s = '1;
      end else begin
         dot_s = DOT_PROD_WIDTH'(sum_s);
      end
`else
      dot_s = DOT_PROD_WIDTH'(sum_s);
`endif
   end

   // Result row selection; out-of-range rows read as zero.
   always_comb begin
      fm_wm_row_out = '0;
      if (int'(read_row) < FEATURE_ROWS) begin
         for (int c = 0; c < WEIGHT_COLS; c++) begin
            fm_wm_row_out[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = buffer_r[read_row][c];
         end
      end else begin
         fm_wm_row_out = '0;
      end
   end

   // Request sequencer, scratch pad and result buffer; read_en is a one-cycle pulse per request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= S_IDLE;
         row_cnt_r      <= '0;
         col_cnt_r      <= '0;
         weight_r       <= '0;
         read_en_r      <= 1'b0;
         read_address_r <= '0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         for (int r = 0; r < FEATURE_ROWS; r++) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
               buffer_r[r][c] <= '0;
            end
         end
      end else begin
         read_en_r <= 1'b0;
         case (state_r)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_r        <= S_REQ_W;
                  row_cnt_r      <= '0;
                  col_cnt_r      <= '0;
                  busy_r         <= 1'b1;
                  done_r         <= 1'b0;
                  read_en_r      <= 1'b1;
                  read_address_r <= ADDR_WIDTH'(WEIGHT_BASE);
               end
            end
            S_REQ_W: state_r <= S_WAIT_W;
            S_WAIT_W: begin
               if (mem_valid) begin
                  weight_r       <= weight_s;
                  state_r        <= S_REQ_F;
                  read_en_r      <= 1'b1;
                  read_address_r <= ADDR_WIDTH'(FEATURE_BASE) + ADDR_WIDTH'(row_cnt_r);
               end
            end
            S_REQ_F: state_r <= S_WAIT_F;
            S_WAIT_F: begin
               if (mem_valid) begin
                  buffer_r[row_cnt_r][col_cnt_r] <= dot_s;
                  if (row_cnt_r == ROW_LAST) begin
                     row_cnt_r <= '0;
                     if (col_cnt_r == COL_LAST) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                     end else begin
                        col_cnt_r      <= col_nxt_s;
                        state_r        <= S_REQ_W;
                        read_en_r      <= 1'b1;
                        read_address_r <= ADDR_WIDTH'(WEIGHT_BASE) + ADDR_WIDTH'(col_nxt_s);
                     end
                  end else begin
                     row_cnt_r      <= row_nxt_s;
                     state_r        <= S_REQ_F;
                     read_en_r      <= 1'b1;
                     read_address_r <= ADDR_WIDTH'(FEATURE_BASE) + ADDR_WIDTH'(row_nxt_s);
                  end
               end
            end
            default: state_r <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_transformation_engine.sv
// Randomized self-checking bench for transformation_engine with a latency-programmable memory model.
module tb_transformation_engine;

   localparam int FR = 6;
   localparam int WC = 3;
   localparam int VL = 96;
   localparam int EW = 5;
   localparam int DW = 16;
   localparam int FBASE = 512;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic              mem_valid;
   logic [VL*EW-1:0]  data_in;
   logic [2:0]        read_row;
   logic              read_en;
   logic [12:0]       read_address;
   logic [WC*DW-1:0]  fm_wm_row_out;
   logic              busy;
   logic              done;

   int f [FR][VL];
   int w [WC][VL];
   int n_tests = 0;
   int n_fail  = 0;

   transformation_engine dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mem_valid(mem_valid),
      .data_in(data_in), .read_row(read_row), .read_en(read_en),
      .read_address(read_address), .fm_wm_row_out(fm_wm_row_out),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint model_entry(input int r, input int c);
      longint s = 0;
      for (int i = 0; i < VL; i++) s += longint'(f[r][i]) * longint'(w[c][i]);
`ifdef TRANSFORM_SAT_EN
      if (s > 65535) s = 65535;
`else
      s = s % 65536;
`endif
      return s;
   endfunction

   task automatic fill(input int mode);
      for (int i = 0; i < VL; i++) begin
         for (int r = 0; r < FR; r++)
            f[r][i] = (mode == 0) ? 1 : (mode == 1) ? 31 : (mode == 2) ? r : int'($urandom_range(0, 31));
         for (int c = 0; c < WC; c++)
            w[c][i] = (mode == 0) ? 1 : (mode == 1) ? 31 : (mode == 2) ? c + 1 : int'($urandom_range(0, 31));
      end
   endtask

   task automatic drive_data(input int addr);
      for (int i = 0; i < VL; i++)
         data_in[i*EW +: EW] = (addr >= FBASE) ? EW'(f[addr-FBASE][i]) : EW'(w[addr][i]);
   endtask

   task automatic check_buffer(input string tag, input bit zero);
      for (int r = 0; r < FR; r++) begin
         read_row = 3'(r);
         #1;
         for (int c = 0; c < WC; c++)
            check_eq($sformatf("%s r%0d c%0d", tag, r, c),
                     longint'(fm_wm_row_out[c*DW +: DW]), zero ? 64'd0 : model_entry(r, c));
      end
      read_row = 3'd6;
      #1;
      check_eq({tag, " row6"}, longint'(fm_wm_row_out), 64'd0);
   endtask

   task automatic run_job(input int lat, input bit noise, input int abort_at);
      int q[$];
      int edges = 0, cnt = 0, req_addr = 0, cur_col = 0, chk_r = 0, chk_c = 0;
      bit pending = 1'b0, chk = 1'b0;
      for (int c = 0; c < WC; c++) begin
         q.push_back(c);
         for (int r = 0; r < FR; r++) q.push_back(FBASE + r);
      end
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_eq("start done clr", longint'(done), 64'd0);
      check_eq("start busy", longint'(busy), 64'd1);
      check_eq("start addr", longint'(read_address), 64'd0);
      while (1) begin
         if (chk) begin
            check_eq($sformatf("live r%0d c%0d", chk_r, chk_c),
                     longint'(fm_wm_row_out[chk_c*DW +: DW]), model_entry(chk_r, chk_c));
            chk = 1'b0;
         end
         if (done) break;
         if (edges >= 4000) begin
            check_eq("timeout", longint'(edges), 64'd0);
            break;
         end
         mem_valid = 1'b0;
         start = 1'b0;
         if (pending) begin
            cnt--;
            if (cnt == 0) begin
               pending = 1'b0;
               mem_valid = 1'b1;
               drive_data(req_addr);
               if (req_addr >= FBASE) begin
                  chk = 1'b1; chk_r = req_addr - FBASE; chk_c = cur_col;
                  read_row = 3'(chk_r);
               end else begin
                  cur_col = req_addr;
               end
            end
         end
         if (read_en) begin
            if (q.size() == 0) check_eq("extra request", longint'(read_address), -64'sd1);
            else check_eq("req addr", longint'(read_address), longint'(q.pop_front()));
            req_addr = int'(read_address);
            pending = 1'b1;
            cnt = lat;
            if (noise && $urandom_range(0, 1) == 1) begin
               mem_valid = 1'b1;
               data_in = {15{$urandom()}};
            end
         end
         if (noise && busy && $urandom_range(0, 3) == 0) start = 1'b1;
         @(posedge clk);
         edges++;
         if (edges == abort_at) begin
            #1;
            reset_n = 1'b0;
            mem_valid = 1'b0;
            start = 1'b0;
            #1;
            check_eq("abort read_en", longint'(read_en), 64'd0);
            check_eq("abort addr", longint'(read_address), 64'd0);
            check_eq("abort busy", longint'(busy), 64'd0);
            check_eq("abort done", longint'(done), 64'd0);
            check_buffer("abort buf", 1'b1);
            @(negedge clk);
            reset_n = 1'b1;
            return;
         end
         @(negedge clk);
      end
      start = 1'b0;
      mem_valid = 1'b0;
      check_eq("done latency", longint'(edges), longint'((lat + 1) * WC * (FR + 1)));
      check_eq("busy at done", longint'(busy), 64'd0);
      check_eq("requests left", longint'(q.size()), 64'd0);
      check_buffer("buf", 1'b0);
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      mem_valid = 1'b0;
      data_in = '0;
      read_row = 3'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst read_en", longint'(read_en), 64'd0);
      check_eq("rst addr", longint'(read_address), 64'd0);
      check_eq("rst busy", longint'(busy), 64'd0);
      check_eq("rst done", longint'(done), 64'd0);
      check_buffer("rst buf", 1'b1);
      reset_n = 1'b1;
      // mem_valid while idle must be ignored
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         mem_valid = 1'b1;
         data_in = {15{$urandom()}};
      end
      @(negedge clk);
      mem_valid = 1'b0;
      check_eq("idle busy", longint'(busy), 64'd0);
      check_eq("idle read_en", longint'(read_en), 64'd0);
      check_buffer("idle buf", 1'b1);

      fill(0); run_job(1, 1'b0, 0);
      fill(1); run_job(1, 1'b0, 0);
      fill(2); run_job(3, 1'b0, 0);
      fill(3); run_job(int'($urandom_range(1, 4)), 1'b1, 0);
      fill(3); run_job(int'($urandom_range(1, 4)), 1'b1, 0);
      fill(3); run_job(1, 1'b0, 20);
      fill(3); run_job(2, 1'b1, 0);
      fill(2); run_job(1, 1'b1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
